instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 59 +++++
 rtl/instr_encoder_sync_fifo.sv | 73 +++++++
 rtl/instr_encoder.sv | 98 +++++++++
 3 files changed

// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
// Shared RV32 R-type constants: ALU operation codes, the OP major opcode and
// the funct3/funct7 values for each operation. Also used by the decoder, so
// the encoding lives here and not in the encoder itself.
// Contents:
//   alu_op_e        - 3-bit ALU operation code (codes 110/111 are unassigned)
//   OPCODE_OP       - 7'b0110011
//   F3_* / F7_*     - funct3 / funct7 field values
//   alu_op_legal()  - 1 when the code maps to a real operation
//   encode_rtype()  - assembles {funct7, rs2, rs1, funct3, rd, opcode}
// -----------------------------------------------------------------------------
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_e;

  localparam logic [6:0] OPCODE_OP  = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;

  localparam logic [6:0] F7_BASE    = 7'h00;
  localparam logic [6:0] F7_SUB     = 7'h20;

  function automatic logic alu_op_legal(input logic [2:0] op);
    return (op <= 3'b101);
  endfunction

  function automatic logic [31:0] encode_rtype(input logic [2:0] op,
                                               input logic [4:0] rs1,
                                               input logic [4:0] rs2,
                                               input logic [4:0] rd);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = F3_ADD_SUB;
    f7 = F7_BASE;
    case (alu_op_e'(op))
      ALU_ADD: f3 = F3_ADD_SUB;
      ALU_SUB: begin f3 = F3_ADD_SUB; f7 = F7_SUB; end
      ALU_AND: f3 = F3_AND;
      ALU_OR:  f3 = F3_OR;
      ALU_XOR: f3 = F3_XOR;
      ALU_SLT: f3 = F3_SLT;
      default: begin f3 = F3_ADD_SUB; f7 = F7_BASE; end
    endcase
    return {f7, rs2, rs1, f3, rd, OPCODE_OP};
  endfunction

endpackage

// File: rtl/instr_encoder_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with power-of-two depth. The head word is presented
// combinationally and forced to zero while the FIFO is empty.
// Parameters: WIDTH (data width), DEPTH (entries, power of two, >= 2)
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   push_i, wdata_i   - write request / data (ignored while full)
//   pop_i             - read request (ignored while empty)
//   rdata_o           - head word (0 when empty)
//   full_o, empty_o   - status from registered occupancy
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // Full blocks a push even if a pop frees a slot in the same cycle, so
  // the producer-facing ready never depends on the consumer combinationally.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Turns (alu_op, rs1, rs2, rd) requests into RV32 R-type instruction words
// and buffers them in a sync_fifo for a downstream consumer.
// Optional feature: define INSTR_ENC_STATS_EN to add the issue_cnt output.
// Parameter: DEPTH - output FIFO entries (power of two, >= 2)
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   op_valid / op_ready        - request handshake (op_ready = !full)
//   alu_op, rs1, rs2, rd       - request fields
//   instr_valid / instr_ready  - output handshake (instr_valid = !empty)
//   instr                      - head-of-FIFO word, 0 when empty
//   err_illegal / err_clr      - sticky illegal-op flag and its clear
//   issue_cnt                  - (INSTR_ENC_STATS_EN) words handed out, wraps
// -----------------------------------------------------------------------------
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  alu_op,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
`ifdef INSTR_ENC_STATS_EN
  output logic [15:0] issue_cnt,
`endif
  output logic        err_illegal,
  input  logic        err_clr
);

  logic        fifo_full, fifo_empty;
  logic        accept, legal, push, pop;
  logic [31:0] word;
  logic        err_q, err_d;

  assign op_ready    = !fifo_full;
  assign instr_valid = !fifo_empty;

  assign accept = op_valid && op_ready;
  assign legal  = alu_op_legal(alu_op);
  // Illegal requests still complete the handshake but never reach the FIFO.
  assign push   = accept && legal;
  assign pop    = instr_valid && instr_ready;
  assign word   = encode_rtype(alu_op, rs1, rs2, rd);

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (word),
    .pop_i   (pop),
    .rdata_o (instr),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A same-cycle illegal acceptance wins over err_clr.
  always_comb begin
    err_d = err_q;
    if (accept && !legal) err_d = 1'b1;
    else if (err_clr)     err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_illegal = err_q;

`ifdef INSTR_ENC_STATS_EN
  logic [15:0] issue_cnt_q, issue_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    if (pop) issue_cnt_d = issue_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) issue_cnt_q <= '0;
    else        issue_cnt_q <= issue_cnt_d;
  end

  assign issue_cnt = issue_cnt_q;
`endif

endmodule
